// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - instruction fetch front end with one outstanding read and a decode queue
module fetch_unit #(
  parameter int QDEPTH = 2
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic [31:0] pc,
  output logic        PCen,
  input  logic        flush,
  input  logic        halt,
  output logic        imemREN,
  output logic [31:0] imemaddr,
  input  logic        ihit,
  input  logic [31:0] imemload,
  output logic        inst_valid,
  output logic [31:0] inst,
  output logic [31:0] inst_pc,
  input  logic        dec_ready
);

  localparam int PW = $clog2(QDEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] QFULL = CW'(QDEPTH);

  typedef enum logic [1:0] {IDLE, REQ, DROP} state_t;

  state_t          state_q, state_d;
  logic [31:0]     req_addr_q, req_addr_d;
  logic [31:0]     qdata_q [QDEPTH];
  logic [31:0]     qaddr_q [QDEPTH];
  logic [PW-1:0]   rptr_q, wptr_q;
  logic [CW-1:0]   count_q, count_after;
  logic            push, pop;

  // Head of queue is read combinationally so decode sees it the cycle after the push.
  assign inst_valid  = (count_q != '0);
  assign inst        = qdata_q[rptr_q];
  assign inst_pc     = qaddr_q[rptr_q];
  assign imemaddr    = req_addr_q;
  assign pop         = inst_valid && dec_ready;
  assign count_after = count_q + CW'(push) - CW'(pop);

  // State and request-address registers.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q    <= IDLE;
      req_addr_q <= '0;
    end else begin
      state_q    <= state_d;
      req_addr_q <= req_addr_d;
    end
  end

  // Next-state logic; a request in flight is never aborted, a redirect just turns it into DROP.
  always_comb begin
    state_d    = state_q;
    req_addr_d = req_addr_q;
    case (state_q)
      IDLE: begin
        if (!flush && !halt && (count_q < QFULL)) begin
          state_d    = REQ;
          req_addr_d = pc;
        end
      end
      REQ: begin
        if (flush) begin
          state_d = ihit ? IDLE : DROP;
        end else if (ihit) begin
          if (!halt && (count_after < QFULL)) begin
            req_addr_d = req_addr_q + 32'd4;
          end else begin
            state_d = IDLE;
          end
        end
      end
      DROP: begin
        if (ihit) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs: read strobe while a request is live, PC advance on a redirect or an accepted word.
  always_comb begin
    imemREN = (state_q != IDLE);
    push    = (state_q == REQ) && ihit && !flush;
    PCen    = flush | push;
  end

  // Circular instruction queue; a redirect empties it regardless of same-cycle push or pop.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      for (int i = 0; i < QDEPTH; i++) begin
        qdata_q[i] <= '0;
        qaddr_q[i] <= '0;
      end
      rptr_q  <= '0;
      wptr_q  <= '0;
      count_q <= '0;
    end else if (flush) begin
      rptr_q  <= '0;
      wptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (push) begin
        qdata_q[wptr_q] <= imemload;
        qaddr_q[wptr_q] <= req_addr_q;
        wptr_q          <= wptr_q + PW'(1);
      end
      if (pop) begin
        rptr_q <= rptr_q + PW'(1);
      end
      count_q <= count_after;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - directed self-checking bench for fetch_unit
module tb_fetch_unit;

  logic        CLK = 1'b0;
  logic        nRST;
  logic [31:0] pc;
  logic        PCen;
  logic        flush;
  logic        halt;
  logic        imemREN;
  logic [31:0] imemaddr;
  logic        ihit;
  logic [31:0] imemload;
  logic        inst_valid;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        dec_ready;
  logic [31:0] flush_tgt;

  int n_checks = 0;
  int n_errors = 0;

  fetch_unit #(.QDEPTH(2)) dut (
    .CLK(CLK), .nRST(nRST), .pc(pc), .PCen(PCen), .flush(flush), .halt(halt),
    .imemREN(imemREN), .imemaddr(imemaddr), .ihit(ihit), .imemload(imemload),
    .inst_valid(inst_valid), .inst(inst), .inst_pc(inst_pc), .dec_ready(dec_ready)
  );

  always #5 CLK = ~CLK;

  // Memory returns a word tagged by its address.
  assign imemload = imemaddr ^ 32'hDEAD_0000;

  // Program counter register: redirect target on flush, otherwise +4 when enabled.
  always @(posedge CLK or negedge nRST) begin
    if (!nRST) pc <= 32'h0;
    else if (PCen) pc <= flush ? flush_tgt : pc + 32'd4;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge CLK);
    #1;
  endtask

  initial begin
    nRST = 1'b0; flush = 1'b0; halt = 1'b0; ihit = 1'b1; dec_ready = 1'b1; flush_tgt = 32'h0;

    // reset values
    cyc(); cyc(); #1;
    chk("rst_ren", imemREN, 0);
    chk("rst_addr", imemaddr, 0);
    chk("rst_valid", inst_valid, 0);
    chk("rst_inst", inst, 0);
    chk("rst_inst_pc", inst_pc, 0);
    chk("rst_pcen", PCen, 0);
    flush = 1'b1; #1;
    chk("rst_pcen_flush", PCen, 1);
    flush = 1'b0;

    // startup streaming
    cyc(); nRST = 1'b1; #1;
    chk("st_idle_ren", imemREN, 0);
    cyc(); #1;
    chk("st_ren0", imemREN, 1);
    chk("st_addr0", imemaddr, 32'h0);
    chk("st_pcen0", PCen, 1);
    chk("st_valid0", inst_valid, 0);
    cyc(); #1;
    chk("st_addr4", imemaddr, 32'h4);
    chk("st_valid1", inst_valid, 1);
    chk("st_ipc0", inst_pc, 32'h0);
    chk("st_inst0", inst, 32'hDEAD_0000);
    chk("st_pcen1", PCen, 1);
    cyc(); #1;
    chk("st_addr8", imemaddr, 32'h8);
    chk("st_ipc4", inst_pc, 32'h4);
    chk("st_pcen2", PCen, 1);

    // backpressure
    nRST = 1'b0; #1;
    cyc(); dec_ready = 1'b0; nRST = 1'b1; #1;
    chk("bp_idle", imemREN, 0);
    cyc(); #1;
    chk("bp_addr0", imemaddr, 32'h0);
    cyc(); #1;
    chk("bp_addr4", imemaddr, 32'h4);
    chk("bp_ipc0", inst_pc, 32'h0);
    cyc(); #1;
    chk("bp_full_ren", imemREN, 0);
    chk("bp_full_valid", inst_valid, 1);
    cyc(); dec_ready = 1'b1; #1;
    chk("bp_full_ren2", imemREN, 0);
    chk("bp_drain0", inst_pc, 32'h0);
    cyc(); #1;
    chk("bp_drain4", inst_pc, 32'h4);
    chk("bp_drain_ren", imemREN, 0);
    cyc(); #1;
    chk("bp_resume_ren", imemREN, 1);
    chk("bp_resume_addr", imemaddr, 32'h8);
    chk("bp_empty", inst_valid, 0);

    // flush while a read is in flight
    nRST = 1'b0; #1;
    cyc(); nRST = 1'b1; ihit = 1'b0; flush = 1'b1; flush_tgt = 32'h10; #1;
    chk("fl_pcen_idle", PCen, 1);
    cyc(); flush = 1'b0; #1;
    chk("fl_idle_ren", imemREN, 0);
    cyc(); flush = 1'b1; flush_tgt = 32'h200; #1;
    chk("fl_req_addr", imemaddr, 32'h10);
    chk("fl_req_pcen", PCen, 1);
    cyc(); #1;
    chk("fl_drop_ren", imemREN, 1);
    chk("fl_drop_addr", imemaddr, 32'h10);
    cyc(); flush = 1'b0; #1;
    chk("fl_drop_hold", imemaddr, 32'h10);
    chk("fl_drop_pcen", PCen, 0);
    cyc(); ihit = 1'b1; #1;
    chk("fl_drop_hit_pcen", PCen, 0);
    chk("fl_drop_hit_addr", imemaddr, 32'h10);
    cyc(); #1;
    chk("fl_after_ren", imemREN, 0);
    chk("fl_after_valid", inst_valid, 0);
    cyc(); #1;
    chk("fl_new_addr", imemaddr, 32'h200);
    chk("fl_new_ren", imemREN, 1);

    // flush, ihit and pop together
    cyc(); #1;
    chk("fip_addr", imemaddr, 32'h204);
    chk("fip_ipc", inst_pc, 32'h200);
    chk("fip_inst", inst, 32'hDEAD_0200);
    flush = 1'b1; flush_tgt = 32'h400; #1;
    chk("fip_pcen", PCen, 1);
    cyc(); flush = 1'b0; ihit = 1'b0; #1;
    chk("fip_valid", inst_valid, 0);
    chk("fip_ren", imemREN, 0);

    // halt with an outstanding request
    cyc(); halt = 1'b1; #1;
    chk("h_addr", imemaddr, 32'h400);
    chk("h_ren", imemREN, 1);
    cyc(); ihit = 1'b1; #1;
    chk("h_pcen", PCen, 1);
    cyc(); #1;
    chk("h_idle_ren", imemREN, 0);
    chk("h_pushed", inst_valid, 1);
    chk("h_pushed_pc", inst_pc, 32'h400);
    cyc(); #1;
    chk("h_idle_ren2", imemREN, 0);
    chk("h_drained", inst_valid, 0);
    halt = 1'b0;
    cyc(); #1;
    chk("h_resume_addr", imemaddr, 32'h404);
    chk("h_resume_ren", imemREN, 1);

    // address wrap, then asynchronous reset mid-request
    flush = 1'b1; flush_tgt = 32'hFFFF_FFFC; #1;
    cyc(); flush = 1'b0; #1;
    chk("w_idle", imemREN, 0);
    cyc(); #1;
    chk("w_addr_top", imemaddr, 32'hFFFF_FFFC);
    cyc(); ihit = 1'b0; #1;
    chk("w_addr_wrap", imemaddr, 32'h0);
    chk("w_ipc", inst_pc, 32'hFFFF_FFFC);
    chk("w_ren", imemREN, 1);
    chk("w_valid", inst_valid, 1);
    #2 nRST = 1'b0; #1;
    chk("ar_ren", imemREN, 0);
    chk("ar_valid", inst_valid, 0);
    chk("ar_addr", imemaddr, 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
